fpro_timer_slot: RTL and testbench
==================================

Name: fpro_timer_slot

Overview:
- FPro bus responder: the slave-side endpoint for the fp_* master conduits driven by the fpro system.
- Decodes one MMIO slot and implements a 64-bit prescaled free-running timer.
- Supports compare-match, a sticky status flag with interrupt output, and a coherent 64-bit readback via a high-word shadow.
- fp_readdata outputs of several slots are OR-combined upstream, so this block drives zero whenever it is not returning read data.

Parameters:
- SLOT, 0, 6-bit slot index matched against fp_addr[10:5].
- PRESCALE_W, 16, width of the prescale register.

Ports:
- clk_clk  input  1  system clock; all state on rising edge.
- reset_reset_n  input  1  synchronous active-low reset.
- fp_mmio_cs_conduit  input  1  MMIO region select from master.
- fp_addr_conduit  input  21  word address; [10:5] slot, [4:0] register.
- fp_write_conduit  input  1  write strobe, one cycle per access.
- fp_read_conduit  input  1  read strobe, one cycle per access.
- fp_writedata_conduit  input  32  write data.
- fp_readdata_conduit  output  32  registered read data; zero when idle.
- irq  output  1  level interrupt = match flag AND irq_en.

Behaviour:
- Hit = fp_mmio_cs_conduit AND fp_addr_conduit[10:5]==SLOT AND fp_addr_conduit[20:11]==0.
- Register map (word offsets):
  - 0: CNT_LO (RO).
  - 1: CNT_HI_SHADOW (RO).
  - 2: CTRL (RW): bit0 go, bit1 clear (write-only pulse, reads 0), bit2 auto_reload, bit3 irq_en.
  - 3: CMP_LO (RW).
  - 4: CMP_HI (RW).
  - 5: STATUS: bit0 match flag; write 1 clears.
  - 6: PRESCALE (RW, low PRESCALE_W bits; upper bits read 0).
  - 7–31: read 0; writes ignored.
- Reset: count=0, prescale counter=0, CTRL=0, CMP=64'hFFFF_FFFF_FFFF_FFFF, PRESCALE=0, shadow=0, flag=0, fp_readdata=0, irq=0.
- Prescaler:
  - tick asserted when go=1 and the prescale counter equals PRESCALE; the counter then returns to 0, otherwise it increments.
  - go=0 freezes both the prescale counter and count.
  - PRESCALE=0 gives one tick per cycle.
- Count:
  - increments by 1 on tick, with 64-bit wrap (all-ones → 0, no flag).
  - Match: on a tick where count==CMP, flag is set next cycle.
  - If auto_reload=1, count loads 0 instead of incrementing on that tick; otherwise it increments normally.
- Clear: writing CTRL with bit1=1 zeroes count and the prescale counter next cycle. Clear has priority over tick and over auto_reload. The other CTRL bits take that write's values.
- Flag priority: a new match in the same cycle as a STATUS write-1-clear leaves flag=1 (set wins).
- Read path:
  - 1-cycle latency. On a read hit, fp_readdata is loaded next cycle with the selected register; in every other cycle it loads 0. Data is therefore valid exactly one cycle after fp_read.
  - Reading CNT_LO returns count[31:0] and, in the same edge, latches count[63:32] into the shadow. Reading offset 1 returns the shadow, giving a coherent 64-bit pair when LO is read first.
- Simultaneous read and write hit: both are performed; the read returns the pre-write value.
- Write and read strobes without a hit, or with fp_mmio_cs_conduit=0, are ignored.
- CMP writes take effect for the compare on the next cycle.
- Reset mid-operation returns all state to reset values on the next edge, regardless of any access in flight.

Test Plan:
- Reset + idle: hold reset_reset_n=0 for 2 cycles with read strobes active → fp_readdata=0, irq=0. After release, read CTRL → 0; read CMP_LO → 32'hFFFF_FFFF.
- Prescaled count: PRESCALE=3, CTRL=1, wait 40 cycles, CTRL=0, read CNT_LO → 10 (±1 for strobe alignment; exact value checked against the model). Read while go=0 again → unchanged.
- Wrap + shadow: force count near 0x0000_0000_FFFF_FFFF via clear and CMP setup, PRESCALE=0; read LO then HI across the carry → pair is coherent (HI shadow matches the LO sample). Full wrap at all-ones → 0 with flag=0.
- Match/auto-reload/irq: CMP=5, CTRL=0b1101 → flag sets after the count-5 tick, count restarts at 0, irq=1. Write STATUS=1 on the cycle of a second match → flag stays 1.
- Clear precedence: CMP=2, auto_reload=1; write CTRL=0b0011 exactly on a match tick → count=0, flag not set by that tick, go=1 retained.
- Decode/OR-bus: read and write with SLOT+1 or mmio_cs=0 → no state change, fp_readdata=0. Read+write CMP_LO same cycle with 0x1234 → returns old value; next read → 0x1234.

Source files
------------

// File: rtl/fpro_timer_slot.sv
// FPro MMIO slot holding a 64-bit prescaled free-running timer with compare match,
// sticky match flag / interrupt, and a high-word shadow for coherent 64-bit reads.
module fpro_timer_slot #(
  parameter logic [5:0] SLOT       = 6'd0,
  parameter int         PRESCALE_W = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        fp_mmio_cs_conduit,
  input  logic [20:0] fp_addr_conduit,
  input  logic        fp_write_conduit,
  input  logic        fp_read_conduit,
  input  logic [31:0] fp_writedata_conduit,
  output logic [31:0] fp_readdata_conduit,
  output logic        irq
);

  localparam logic [4:0] REG_CNT_LO   = 5'd0;
  localparam logic [4:0] REG_CNT_HI   = 5'd1;
  localparam logic [4:0] REG_CTRL     = 5'd2;
  localparam logic [4:0] REG_CMP_LO   = 5'd3;
  localparam logic [4:0] REG_CMP_HI   = 5'd4;
  localparam logic [4:0] REG_STATUS   = 5'd5;
  localparam logic [4:0] REG_PRESCALE = 5'd6;

  logic [63:0]           count_q, count_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [63:0]           cmp_q, cmp_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  go_q, go_d;
  logic                  auto_reload_q, auto_reload_d;
  logic                  irq_en_q, irq_en_d;
  logic                  flag_q, flag_d;
  logic                  irq_q, irq_d;

  logic       hit_s, wr_s, rd_s, clr_s, tick_s, match_s;
  logic [4:0] off_s;

  assign hit_s   = fp_mmio_cs_conduit && (fp_addr_conduit[10:5] == SLOT)
                   && (fp_addr_conduit[20:11] == 10'd0);
  assign off_s   = fp_addr_conduit[4:0];
  assign wr_s    = hit_s && fp_write_conduit;
  assign rd_s    = hit_s && fp_read_conduit;
  assign clr_s   = wr_s && (off_s == REG_CTRL) && fp_writedata_conduit[1];
  assign tick_s  = go_q && (pcnt_q == prescale_q);
  // A clear in the same cycle suppresses the match as well as the count update.
  assign match_s = tick_s && !clr_s && (count_q == cmp_q);

  // Next-state logic for timer, control registers and read path.
  always_comb begin
    count_d       = count_q;
    pcnt_d        = pcnt_q;
    prescale_d    = prescale_q;
    cmp_d         = cmp_q;
    shadow_d      = shadow_q;
    go_d          = go_q;
    auto_reload_d = auto_reload_q;
    irq_en_d      = irq_en_q;
    flag_d        = flag_q;
    rdata_d       = 32'd0;

    if (clr_s) begin
      count_d = 64'd0;
      pcnt_d  = '0;
    end else if (tick_s) begin
      pcnt_d = '0;
      if (match_s && auto_reload_q) begin
        count_d = 64'd0;
      end else begin
        count_d = count_q + 64'd1;
      end
    end else if (go_q) begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end else begin
      pcnt_d = pcnt_q;
    end

    if (wr_s) begin
      case (off_s)
        REG_CTRL: begin
          go_d          = fp_writedata_conduit[0];
          auto_reload_d = fp_writedata_conduit[2];
          irq_en_d      = fp_writedata_conduit[3];
        end
        REG_CMP_LO:   cmp_d[31:0]  = fp_writedata_conduit;
        REG_CMP_HI:   cmp_d[63:32] = fp_writedata_conduit;
        REG_PRESCALE: prescale_d   = fp_writedata_conduit[PRESCALE_W-1:0];
        default:      cmp_d        = cmp_q;
      endcase
    end else begin
      cmp_d = cmp_q;
    end

    // Set beats write-1-clear when both land in the same cycle.
    if (match_s) begin
      flag_d = 1'b1;
    end else if (wr_s && (off_s == REG_STATUS) && fp_writedata_conduit[0]) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end

    if (rd_s) begin
      case (off_s)
        REG_CNT_LO: begin
          rdata_d  = count_q[31:0];
          shadow_d = count_q[63:32];
        end
        REG_CNT_HI:   rdata_d = shadow_q;
        REG_CTRL:     rdata_d = {28'd0, irq_en_q, auto_reload_q, 1'b0, go_q};
        REG_CMP_LO:   rdata_d = cmp_q[31:0];
        REG_CMP_HI:   rdata_d = cmp_q[63:32];
        REG_STATUS:   rdata_d = {31'd0, flag_q};
        REG_PRESCALE: rdata_d = 32'(prescale_q);
        default:      rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end

    irq_d = flag_d && irq_en_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      count_q       <= 64'd0;
      pcnt_q        <= '0;
      prescale_q    <= '0;
      cmp_q         <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q      <= 32'd0;
      rdata_q       <= 32'd0;
      go_q          <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      flag_q        <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      count_q       <= count_d;
      pcnt_q        <= pcnt_d;
      prescale_q    <= prescale_d;
      cmp_q         <= cmp_d;
      shadow_q      <= shadow_d;
      rdata_q       <= rdata_d;
      go_q          <= go_d;
      auto_reload_q <= auto_reload_d;
      irq_en_q      <= irq_en_d;
      flag_q        <= flag_d;
      irq_q         <= irq_d;
    end
  end

  assign fp_readdata_conduit = rdata_q;
  assign irq                 = irq_q;

endmodule

// File: tb/tb_fpro_timer_slot.sv
// Directed bench for fpro_timer_slot: reads push expected data into a scoreboard
// queue, a monitor pops and compares one cycle after each read strobe.
module tb_fpro_timer_slot;

  localparam logic [5:0] SLOT   = 6'd3;
  localparam logic [5:0] OTHER  = 6'd4;
  localparam logic [4:0] R_LO   = 5'd0;
  localparam logic [4:0] R_HI   = 5'd1;
  localparam logic [4:0] R_CTRL = 5'd2;
  localparam logic [4:0] R_CMPL = 5'd3;
  localparam logic [4:0] R_CMPH = 5'd4;
  localparam logic [4:0] R_STAT = 5'd5;
  localparam logic [4:0] R_PRE  = 5'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [20:0] addr;
  logic        wr;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rd_pend = 1'b0;
  logic seen_edge = 1'b0;

  always #5 clk = ~clk;

  fpro_timer_slot #(.SLOT(SLOT), .PRESCALE_W(16)) dut (
    .clk_clk              (clk),
    .reset_reset_n        (rst_n),
    .fp_mmio_cs_conduit   (cs),
    .fp_addr_conduit      (addr),
    .fp_write_conduit     (wr),
    .fp_read_conduit      (rd),
    .fp_writedata_conduit (wdata),
    .fp_readdata_conduit  (rdata),
    .irq                  (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Any read strobe outside reset yields data on the following cycle.
  always @(posedge clk) begin
    rd_pend   <= rd && rst_n;
    seen_edge <= 1'b1;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got %h, expected no read data", rdata);
      end else begin
        e = exp_q.pop_front();
        check(e.name, rdata, e.exp);
      end
    end else if (seen_edge) begin
      check("idle_zero", rdata, 32'd0);
    end
  end

  // One bus cycle: drive at a falling edge, sampled at the next rising edge.
  task automatic acc(input logic c, input logic [9:0] hi, input logic [5:0] slot,
                     input logic [4:0] off, input logic w, input logic r,
                     input logic [31:0] d, input logic [31:0] exp, input string name);
    exp_t e;
    cs = c; addr = {hi, slot, off}; wr = w; rd = r; wdata = d;
    if (r) begin
      e.exp = exp;
      e.name = name;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cs = 1'b0; addr = 21'd0; wr = 1'b0; rd = 1'b0; wdata = 32'd0;
  endtask

  task automatic wreg(input logic [4:0] off, input logic [31:0] d);
    acc(1'b1, 10'd0, SLOT, off, 1'b1, 1'b0, d, 32'd0, "");
  endtask

  task automatic rreg(input logic [4:0] off, input logic [31:0] exp, input string name);
    acc(1'b1, 10'd0, SLOT, off, 1'b0, 1'b1, 32'd0, exp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b1; addr = {10'd0, SLOT, R_CMPL}; rd = 1'b1; wr = 1'b0; wdata = 32'd0;
    idle(2);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1; cs = 1'b0; rd = 1'b0; addr = 21'd0;

    rreg(R_CTRL, 32'd0, "reset_ctrl");
    rreg(R_CMPL, 32'hFFFF_FFFF, "reset_cmp_lo");
    rreg(R_CMPH, 32'hFFFF_FFFF, "reset_cmp_hi");
    rreg(R_STAT, 32'd0, "reset_status");

    // Prescale 3: one tick every 4 cycles over 40 cycles.
    wreg(R_PRE, 32'hABCD_0003);
    rreg(R_PRE, 32'd3, "prescale_rb");
    wreg(R_CTRL, 32'd1);
    idle(39);
    wreg(R_CTRL, 32'd0);
    rreg(R_LO, 32'd10, "prescaled_cnt");
    idle(5);
    rreg(R_LO, 32'd10, "frozen_cnt");
    rreg(R_CTRL, 32'd0, "ctrl_stopped");

    // Carry across bit 32 with LO/HI pairs read while running.
    wreg(R_PRE, 32'd0);
    wreg(R_CMPH, 32'd7);
    force dut.count_q = 64'h0000_0000_FFFF_FFFD;
    idle(1);
    release dut.count_q;
    wreg(R_CTRL, 32'd1);
    rreg(R_LO, 32'hFFFF_FFFD, "pair1_lo");
    rreg(R_HI, 32'd0, "pair1_hi");
    rreg(R_LO, 32'hFFFF_FFFF, "pair2_lo");
    rreg(R_HI, 32'd0, "pair2_hi_shadow");
    rreg(R_LO, 32'd1, "pair3_lo");
    rreg(R_HI, 32'd1, "pair3_hi");
    wreg(R_CTRL, 32'd0);

    // 64-bit wrap to zero raises no flag.
    force dut.count_q = 64'hFFFF_FFFF_FFFF_FFFE;
    idle(1);
    release dut.count_q;
    wreg(R_CTRL, 32'd1);
    idle(1);
    wreg(R_CTRL, 32'd0);
    rreg(R_LO, 32'd0, "wrap_lo");
    rreg(R_HI, 32'd0, "wrap_hi");
    rreg(R_STAT, 32'd0, "wrap_no_flag");

    // Match at 5 with auto-reload and irq; set beats clear on the second match.
    wreg(R_CTRL, 32'd2);
    wreg(R_CMPH, 32'd0);
    wreg(R_CMPL, 32'd5);
    wreg(R_CTRL, 32'hD);
    idle(5);
    check("irq_before_match", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_after_match", {31'd0, irq}, 32'd1);
    rreg(R_STAT, 32'd1, "match_flag");
    rreg(R_LO, 32'd1, "reload_cnt");
    idle(3);
    wreg(R_STAT, 32'd1);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    rreg(R_STAT, 32'd1, "flag_set_wins");
    wreg(R_STAT, 32'd1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rreg(R_STAT, 32'd0, "flag_w1c");
    wreg(R_CTRL, 32'd0);

    // Clear lands on a match tick.
    wreg(R_CTRL, 32'd2);
    wreg(R_CMPL, 32'd2);
    wreg(R_CTRL, 32'd5);
    idle(2);
    wreg(R_CTRL, 32'd3);
    rreg(R_STAT, 32'd0, "clr_no_flag");
    rreg(R_LO, 32'd1, "clr_cnt");
    rreg(R_CTRL, 32'd1, "clr_ctrl_rb");
    wreg(R_CTRL, 32'd0);
    wreg(R_STAT, 32'd1);

    // Decode misses and simultaneous read/write.
    acc(1'b1, 10'd0, OTHER, R_CMPL, 1'b1, 1'b1, 32'hDEAD, 32'd0, "other_slot_rd");
    acc(1'b0, 10'd0, SLOT, R_CMPL, 1'b1, 1'b1, 32'hBEEF, 32'd0, "cs_low_rd");
    acc(1'b1, 10'd1, SLOT, R_CMPL, 1'b1, 1'b1, 32'hCAFE, 32'd0, "high_addr_rd");
    rreg(R_CMPL, 32'd2, "cmp_unchanged");
    wreg(5'd7, 32'hFFFF_FFFF);
    rreg(5'd7, 32'd0, "reserved_7");
    rreg(5'd31, 32'd0, "reserved_31");
    acc(1'b1, 10'd0, SLOT, R_CMPL, 1'b1, 1'b1, 32'h1234, 32'd2, "rw_old_value");
    rreg(R_CMPL, 32'h1234, "rw_new_value");

    // Reset while running, with accesses in flight.
    wreg(R_CTRL, 32'd9);
    idle(3);
    rst_n = 1'b0; cs = 1'b1; addr = {10'd0, SLOT, R_CMPL}; rd = 1'b1; wr = 1'b1; wdata = 32'h55;
    idle(1);
    rst_n = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 21'd0; wdata = 32'd0;
    rreg(R_LO, 32'd0, "midreset_cnt");
    rreg(R_CMPL, 32'hFFFF_FFFF, "midreset_cmp");
    rreg(R_CTRL, 32'd0, "midreset_ctrl");
    rreg(R_PRE, 32'd0, "midreset_pre");
    check("midreset_irq", {31'd0, irq}, 32'd0);

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
